// File: rtl/cache_pkg.sv
// Shared definitions for the store buffer: default sizing and the byte-lane merge
// used by both the coalescing write path and load forwarding.
package cache_pkg;

    localparam int STB_DEFAULT_DEPTH = 4;

    // Pick the new byte where its enable is set, otherwise keep the old one.
    function automatic logic [7:0] byte_merge(
        input logic [7:0] old_byte,
        input logic [7:0] new_byte,
        input logic       be
    );
        return be ? new_byte : old_byte;
    endfunction

endpackage

// File: rtl/stb_fwd_select.sv
// Store-to-load forwarding select: per byte, the youngest valid word-matching entry
// with that byte enabled supplies the data; reports full and partial coverage.
module stb_fwd_select
    import cache_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = STB_DEFAULT_DEPTH,
    localparam int BE_W  = DATA_W / 8,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]  valid_i,
    input  logic [ADDR_W-1:0] addr_i [DEPTH],
    input  logic [DATA_W-1:0] data_i [DEPTH],
    input  logic [BE_W-1:0]   be_i   [DEPTH],
    input  logic [IDX_W-1:0]  head_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic [BE_W-1:0]   ld_be_i,
    output logic [DATA_W-1:0] data_o,
    output logic              hit_o,
    output logic              partial_o
);

    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(BE_W - 1);

    logic [DATA_W-1:0] fwd_all;
    logic [BE_W-1:0]   src_all;
    logic [BE_W-1:0]   covered;
    logic [IDX_W-1:0]  idx;
    logic              match;

    always_comb begin
        // NOTE: every variable gets a default before the loop, so no path leaves it
        // unassigned and no latch is inferred.
        fwd_all = '0;
        src_all = '0;
        idx     = head_i;
        match   = 1'b0;
        // Walk oldest to youngest so younger entries overwrite older bytes.
        for (int k = 0; k < DEPTH; k++) begin
            idx   = head_i + IDX_W'(k);
            match = valid_i[idx] && ((addr_i[idx] & WORD_MASK) == (ld_addr_i & WORD_MASK));
            for (int b = 0; b < BE_W; b++) begin
                src_all[b]        = src_all[b] | (match & be_i[idx][b]);
                fwd_all[8*b +: 8] = byte_merge(fwd_all[8*b +: 8], data_i[idx][8*b +: 8],
                                               match & be_i[idx][b]);
            end
        end
    end

    always_comb begin
        covered = src_all & ld_be_i;
        data_o  = '0;
        for (int b = 0; b < BE_W; b++) begin
            data_o[8*b +: 8] = byte_merge(8'h00, fwd_all[8*b +: 8], covered[b]);
        end
        hit_o     = (ld_be_i != '0) && (covered == ld_be_i);
        partial_o = (covered != '0) && !hit_o;
    end

endmodule

// File: rtl/stb_coalesce.sv
// In-order store buffer between memory stage and data cache, with optional merge of
// byte-masked stores into the youngest entry and per-byte load forwarding.
module stb_coalesce
    import cache_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int DEPTH    = STB_DEFAULT_DEPTH,
    parameter int COALESCE = 1,
    localparam int BE_W    = DATA_W / 8,
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_st_valid,
    input  logic [ADDR_W-1:0] i_st_addr,
    input  logic [DATA_W-1:0] i_st_data,
    input  logic [BE_W-1:0]   i_st_be,
    output logic              o_st_ready,
    output logic              o_cm_valid,
    output logic [ADDR_W-1:0] o_cm_addr,
    output logic [DATA_W-1:0] o_cm_data,
    output logic [BE_W-1:0]   o_cm_be,
    input  logic              i_cm_ack,
    input  logic [ADDR_W-1:0] i_ld_addr,
    input  logic [BE_W-1:0]   i_ld_be,
    output logic              o_ld_hit,
    output logic              o_ld_partial,
    output logic [DATA_W-1:0] o_ld_data,
    input  logic              i_drain,
    output logic              o_empty,
    output logic [CNT_W-1:0]  o_count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(BE_W - 1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [BE_W-1:0]   be;
    } entry_t;

    entry_t            entry_q [DEPTH];
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;

    logic [IDX_W-1:0]  head_idx, tail_idx, young_idx;
    logic [CNT_W-1:0]  count;
    logic              full, empty, coalesce_ok;
    logic              push, push_new, pop;
    logic [DATA_W-1:0] merged_data;

    assign head_idx  = head_q[IDX_W-1:0];
    assign tail_idx  = tail_q[IDX_W-1:0];
    assign young_idx = tail_idx - IDX_W'(1);
    assign count     = CNT_W'(tail_q - head_q);
    assign empty     = (head_q == tail_q);
    assign full      = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);

    // count >= 2 keeps the head, which the cache may be writing, out of the merge.
    assign coalesce_ok = (COALESCE != 0) && (count >= CNT_W'(2)) &&
                         ((entry_q[young_idx].addr & WORD_MASK) == (i_st_addr & WORD_MASK));

    assign o_st_ready = !i_drain && (!full || coalesce_ok);
    assign push       = i_st_valid && o_st_ready;
    assign push_new   = push && !coalesce_ok;
    assign pop        = i_cm_ack && !empty;

    assign o_cm_valid = !empty;
    assign o_cm_addr  = entry_q[head_idx].addr;
    assign o_cm_data  = entry_q[head_idx].data;
    assign o_cm_be    = entry_q[head_idx].be;
    assign o_empty    = empty;
    assign o_count    = count;

    always_comb begin
        merged_data = entry_q[young_idx].data;
        for (int b = 0; b < BE_W; b++) begin
            merged_data[8*b +: 8] = byte_merge(entry_q[young_idx].data[8*b +: 8],
                                               i_st_data[8*b +: 8], i_st_be[b]);
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        valid_d = valid_q;
        if (pop) begin
            valid_d[head_idx] = 1'b0;
            head_d            = head_q + PTR_W'(1);
        end
        if (push_new) begin
            valid_d[tail_idx] = 1'b1;
            tail_d            = tail_q + PTR_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            valid_q <= valid_d;
        end
    end

    // NOTE: entry payload has no reset; the valid bits and pointers alone decide
    // what is live, so clearing the array would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (push_new) begin
            entry_q[tail_idx].addr <= i_st_addr & WORD_MASK;
            entry_q[tail_idx].data <= i_st_data;
            entry_q[tail_idx].be   <= i_st_be;
        end else if (push) begin
            entry_q[young_idx].data <= merged_data;
            entry_q[young_idx].be   <= entry_q[young_idx].be | i_st_be;
        end
    end

    logic [ADDR_W-1:0] ent_addr [DEPTH];
    logic [DATA_W-1:0] ent_data [DEPTH];
    logic [BE_W-1:0]   ent_be   [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_unpack
        assign ent_addr[i] = entry_q[i].addr;
        assign ent_data[i] = entry_q[i].data;
        assign ent_be[i]   = entry_q[i].be;
    end

    stb_fwd_select #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fwd (
        .valid_i   (valid_q),
        .addr_i    (ent_addr),
        .data_i    (ent_data),
        .be_i      (ent_be),
        .head_i    (head_idx),
        .ld_addr_i (i_ld_addr),
        .ld_be_i   (i_ld_be),
        .data_o    (o_ld_data),
        .hit_o     (o_ld_hit),
        .partial_o (o_ld_partial)
    );

endmodule

// File: tb/tb_stb_coalesce.sv
// Self-checking bench for stb_coalesce: a queue model of the buffer predicts store
// acceptance and the commit stream; forwarding is checked against fixed tables.
module tb_stb_coalesce;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int BE_W   = 4;
    localparam int CNT_W  = 3;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } ent_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        hit;
        logic        part;
        logic [31:0] data;
    } ld_vec_t;

    ent_t sb[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              i_st_valid = 1'b0;
    logic [ADDR_W-1:0] i_st_addr  = '0;
    logic [DATA_W-1:0] i_st_data  = '0;
    logic [BE_W-1:0]   i_st_be    = '0;
    logic              i_cm_ack   = 1'b0;
    logic [ADDR_W-1:0] i_ld_addr  = '0;
    logic [BE_W-1:0]   i_ld_be    = '0;
    logic              i_drain    = 1'b0;
    logic              o_st_ready, o_cm_valid, o_ld_hit, o_ld_partial, o_empty;
    logic [ADDR_W-1:0] o_cm_addr;
    logic [DATA_W-1:0] o_cm_data, o_ld_data;
    logic [BE_W-1:0]   o_cm_be;
    logic [CNT_W-1:0]  o_count;

    stb_coalesce #(
        .ADDR_W (ADDR_W), .DATA_W (DATA_W), .DEPTH (DEPTH), .COALESCE (1)
    ) dut (
        .clk (clk), .rst (rst),
        .i_st_valid (i_st_valid), .i_st_addr (i_st_addr), .i_st_data (i_st_data),
        .i_st_be (i_st_be), .o_st_ready (o_st_ready),
        .o_cm_valid (o_cm_valid), .o_cm_addr (o_cm_addr), .o_cm_data (o_cm_data),
        .o_cm_be (o_cm_be), .i_cm_ack (i_cm_ack),
        .i_ld_addr (i_ld_addr), .i_ld_be (i_ld_be), .o_ld_hit (o_ld_hit),
        .o_ld_partial (o_ld_partial), .o_ld_data (o_ld_data),
        .i_drain (i_drain), .o_empty (o_empty), .o_count (o_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] be_mask(input logic [3:0] be);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{be[b]}};
        return m;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Offer a store for one cycle; the model predicts acceptance and tracks the result.
    task automatic push_store(input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] be, input string tag);
        bit full, coal, exp_ready;
        i_st_valid = 1'b1; i_st_addr = a; i_st_data = d; i_st_be = be;
        #1;
        full      = (sb.size() == DEPTH);
        coal      = (sb.size() >= 2) && (sb[$].addr == (a & ~32'h3));
        exp_ready = !i_drain && (!full || coal);
        total_cnt++;
        if (o_st_ready !== exp_ready)
            $display("FAIL %s st_ready: got %b want %b", tag, o_st_ready, exp_ready);
        else pass_cnt++;
        if (exp_ready) begin
            if (coal) begin
                sb[$].data = (sb[$].data & ~be_mask(be)) | (d & be_mask(be));
                sb[$].be   = sb[$].be | be;
            end else begin
                sb.push_back('{addr: a & ~32'h3, data: d & be_mask(be), be: be});
            end
        end
        cyc();
        i_st_valid = 1'b0;
    endtask

    // Acknowledge the head for one cycle and compare it against the oldest model entry.
    task automatic ack_head(input string tag);
        ent_t h;
        i_cm_ack = 1'b1;
        #1;
        if (sb.size() == 0) begin
            total_cnt++;
            $display("FAIL %s ack_head: model empty, DUT cm_valid=%b", tag, o_cm_valid);
        end else begin
            h = sb.pop_front();
            total_cnt++;
            if (o_cm_valid !== 1'b1) $display("FAIL %s cm_valid: got %b want 1", tag, o_cm_valid);
            else pass_cnt++;
            total_cnt++;
            if (o_cm_addr !== h.addr) $display("FAIL %s cm_addr: got %h want %h", tag, o_cm_addr, h.addr);
            else pass_cnt++;
            total_cnt++;
            if (o_cm_be !== h.be) $display("FAIL %s cm_be: got %h want %h", tag, o_cm_be, h.be);
            else pass_cnt++;
            total_cnt++;
            if ((o_cm_data & be_mask(h.be)) !== h.data)
                $display("FAIL %s cm_data: got %h want %h", tag, o_cm_data & be_mask(h.be), h.data);
            else pass_cnt++;
        end
        cyc();
        i_cm_ack = 1'b0;
    endtask

    task automatic test_reset();
        i_ld_addr = 32'h100; i_ld_be = 4'hF;
        #2;
        total_cnt++; if (o_st_ready !== 1'b1) $display("FAIL rst st_ready: got %b want 1", o_st_ready); else pass_cnt++;
        total_cnt++; if (o_cm_valid !== 1'b0) $display("FAIL rst cm_valid: got %b want 0", o_cm_valid); else pass_cnt++;
        total_cnt++; if (o_empty !== 1'b1) $display("FAIL rst empty: got %b want 1", o_empty); else pass_cnt++;
        total_cnt++; if (o_count !== 3'd0) $display("FAIL rst count: got %0d want 0", o_count); else pass_cnt++;
        total_cnt++; if (o_ld_hit !== 1'b0) $display("FAIL rst ld_hit: got %b want 0", o_ld_hit); else pass_cnt++;
        total_cnt++; if (o_ld_partial !== 1'b0) $display("FAIL rst ld_partial: got %b want 0", o_ld_partial); else pass_cnt++;
        total_cnt++; if (o_ld_data !== 32'h0) $display("FAIL rst ld_data: got %h want 0", o_ld_data); else pass_cnt++;
        #10;
        rst = 1'b1;
        cyc();
    endtask

    task automatic test_basic();
        push_store(32'h100, 32'h11223344, 4'hF, "basic");
        total_cnt++; if (o_cm_valid !== 1'b1) $display("FAIL basic cm_valid: got %b want 1", o_cm_valid); else pass_cnt++;
        total_cnt++; if (o_count !== 3'd1) $display("FAIL basic count: got %0d want 1", o_count); else pass_cnt++;
        ack_head("basic");
        total_cnt++; if (o_empty !== 1'b1) $display("FAIL basic empty: got %b want 1", o_empty); else pass_cnt++;
        total_cnt++; if (o_cm_valid !== 1'b0) $display("FAIL basic cm_valid_after: got %b want 0", o_cm_valid); else pass_cnt++;
    endtask

    task automatic test_full_coalesce();
        for (int i = 0; i < 4; i++)
            push_store(32'h300 + 32'(4 * i), 32'h11110300 + 32'(i), 4'hF, "fill");
        total_cnt++; if (o_count !== 3'd4) $display("FAIL full count: got %0d want 4", o_count); else pass_cnt++;
        push_store(32'h310, 32'hDEADBEEF, 4'hF, "full_block");
        push_store(32'h30E, 32'h0000EE00, 4'h2, "full_merge");
        total_cnt++; if (o_count !== 3'd4) $display("FAIL merge count: got %0d want 4", o_count); else pass_cnt++;
        // Ack while full does not free a slot for a non-merging store in the same cycle.
        i_st_valid = 1'b1; i_st_addr = 32'h320; i_st_data = 32'h12345678; i_st_be = 4'hF;
        #1;
        total_cnt++; if (o_st_ready !== 1'b0) $display("FAIL pop_push st_ready: got %b want 0", o_st_ready); else pass_cnt++;
        ack_head("pop_push");
        i_st_valid = 1'b0;
        total_cnt++; if (o_count !== 3'd3) $display("FAIL pop_push count: got %0d want 3", o_count); else pass_cnt++;
        while (sb.size() != 0) ack_head("full_drain");
    endtask

    task automatic test_forward();
        ld_vec_t vec [6];
        push_store(32'h200, 32'h0000AABB, 4'h3, "fwd0");
        push_store(32'h204, 32'h55667788, 4'hF, "fwd1");
        push_store(32'h200, 32'hCCDD0000, 4'hC, "fwd2");
        total_cnt++; if (o_count !== 3'd3) $display("FAIL fwd count: got %0d want 3", o_count); else pass_cnt++;
        vec[0] = '{32'h200, 4'hF, 1'b1, 1'b0, 32'hCCDDAABB};
        vec[1] = '{32'h202, 4'hC, 1'b1, 1'b0, 32'hCCDD0000};
        vec[2] = '{32'h204, 4'h6, 1'b1, 1'b0, 32'h00667700};
        vec[3] = '{32'h208, 4'hF, 1'b0, 1'b0, 32'h00000000};
        vec[4] = '{32'h200, 4'h0, 1'b0, 1'b0, 32'h00000000};
        vec[5] = '{32'h200, 4'hF, 1'b1, 1'b0, 32'hCCDDAAEE};
        for (int i = 0; i < 6; i++) begin
            // The last probe follows a merge of byte 0 into the youngest 0x200 entry.
            if (i == 5) push_store(32'h200, 32'h000000EE, 4'h1, "fwd_merge");
            i_ld_addr = vec[i].addr; i_ld_be = vec[i].be;
            #1;
            total_cnt++; if (o_ld_hit !== vec[i].hit) $display("FAIL fwd%0d ld_hit: got %b want %b", i, o_ld_hit, vec[i].hit); else pass_cnt++;
            total_cnt++; if (o_ld_partial !== vec[i].part) $display("FAIL fwd%0d ld_partial: got %b want %b", i, o_ld_partial, vec[i].part); else pass_cnt++;
            total_cnt++; if (o_ld_data !== vec[i].data) $display("FAIL fwd%0d ld_data: got %h want %h", i, o_ld_data, vec[i].data); else pass_cnt++;
        end
        while (sb.size() != 0) ack_head("fwd_drain");
    endtask

    task automatic test_partial();
        i_ld_addr = 32'h200; i_ld_be = 4'hF;
        i_st_valid = 1'b1; i_st_addr = 32'h200; i_st_data = 32'h0000AABB; i_st_be = 4'h3;
        #1;
        total_cnt++; if (o_ld_partial !== 1'b0 || o_ld_data !== 32'h0)
            $display("FAIL same_cycle_fwd: got partial=%b data=%h want 0/00000000", o_ld_partial, o_ld_data); else pass_cnt++;
        sb.push_back('{addr: 32'h200, data: 32'h0000AABB, be: 4'h3});
        cyc();
        i_st_valid = 1'b0;
        #1;
        total_cnt++; if (o_ld_partial !== 1'b1) $display("FAIL part ld_partial: got %b want 1", o_ld_partial); else pass_cnt++;
        total_cnt++; if (o_ld_hit !== 1'b0) $display("FAIL part ld_hit: got %b want 0", o_ld_hit); else pass_cnt++;
        total_cnt++; if (o_ld_data !== 32'h0000AABB) $display("FAIL part ld_data: got %h want 0000aabb", o_ld_data); else pass_cnt++;
        i_ld_be = 4'h1;
        #1;
        total_cnt++; if (o_ld_hit !== 1'b1 || o_ld_data !== 32'h000000BB)
            $display("FAIL part_byte0: got hit=%b data=%h want 1/000000bb", o_ld_hit, o_ld_data); else pass_cnt++;
        i_ld_be = 4'hF; i_cm_ack = 1'b1;
        #1;
        total_cnt++; if (o_ld_partial !== 1'b1) $display("FAIL popping_visible: got %b want 1", o_ld_partial); else pass_cnt++;
        i_cm_ack = 1'b0;
        ack_head("part");
        #1;
        total_cnt++; if (o_ld_partial !== 1'b0 || o_empty !== 1'b1)
            $display("FAIL part_after_pop: got partial=%b empty=%b want 0/1", o_ld_partial, o_empty); else pass_cnt++;
        i_ld_be = 4'h0;
    endtask

    task automatic test_single_entry();
        push_store(32'h400, 32'hA1A2A3A4, 4'hF, "single0");
        push_store(32'h400, 32'h000000B5, 4'h1, "single1");
        total_cnt++; if (o_count !== 3'd2) $display("FAIL single count: got %0d want 2", o_count); else pass_cnt++;
        ack_head("single_head");
        ack_head("single_next");
    endtask

    task automatic test_drain();
        for (int i = 0; i < 3; i++)
            push_store(32'h500 + 32'(4 * i), 32'h50505050 + 32'(i), 4'hF, "drain_fill");
        i_drain = 1'b1;
        i_st_valid = 1'b1; i_st_addr = 32'h600; i_st_data = 32'h66666666; i_st_be = 4'hF;
        for (int c = 0; c < 7; c++) begin
            #1;
            total_cnt++; if (o_st_ready !== 1'b0) $display("FAIL drain%0d st_ready: got %b want 0", c, o_st_ready); else pass_cnt++;
            total_cnt++; if (o_empty !== (sb.size() == 0)) $display("FAIL drain%0d empty: got %b want %b", c, o_empty, sb.size() == 0); else pass_cnt++;
            if (c % 2 == 0 && c < 6) ack_head("drain");
            else cyc();
        end
        i_st_valid = 1'b0; i_drain = 1'b0;

        for (int i = 0; i < 3; i++)
            push_store(32'h700 + 32'(4 * i), 32'h70707070 + 32'(i), 4'hF, "rst_fill");
        i_drain = 1'b1;
        ack_head("rst_drain");
        rst = 1'b0;
        #1;
        total_cnt++; if (o_cm_valid !== 1'b0) $display("FAIL midrst cm_valid: got %b want 0", o_cm_valid); else pass_cnt++;
        total_cnt++; if (o_count !== 3'd0) $display("FAIL midrst count: got %0d want 0", o_count); else pass_cnt++;
        sb.delete();
        i_drain = 1'b0;
        #3;
        rst = 1'b1;
        cyc();
        i_ld_addr = 32'h700; i_ld_be = 4'hF;
        #1;
        total_cnt++; if (o_ld_hit !== 1'b0 || o_ld_data !== 32'h0 || o_empty !== 1'b1)
            $display("FAIL postrst: got hit=%b data=%h empty=%b want 0/00000000/1", o_ld_hit, o_ld_data, o_empty); else pass_cnt++;
        i_ld_be = 4'h0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_coalesce();
        test_forward();
        test_partial();
        test_single_entry();
        test_drain();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
